// File: rtl/inst_fetch_resp_pkg.sv
// Shared types for the instruction-fetch responder: FSM encoding and alignment helper.
package inst_fetch_resp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StDrop = 2'b10
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_resp.sv
// Instruction-side responder: fetches the word at pc_i over a req/ack bus, keeps a one-entry
// buffer so a re-presented PC is served without a new transaction, and stalls the PC meanwhile.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              addr_err_o,
  output logic              stallreq_o
);

  fetch_state_e      state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] inst_q;
  logic              inst_valid_q;
  logic              addr_err_q;
  logic [ADDR_W-1:0] buf_addr_q;

  logic aligned;
  logic hit;
  logic abandon;

  assign aligned = is_word_aligned(pc_i[1:0]);
  assign hit     = inst_valid_q & (pc_i == buf_addr_q) & ~addr_err_q;
  assign abandon = flush_i | ~ce_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      buf_addr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
          end else if (!ce_i) begin
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
          end else if (!aligned) begin
            // Misaligned fetch is answered locally with an error flag, never sent to memory.
            inst_q       <= '0;
            inst_valid_q <= 1'b1;
            addr_err_q   <= 1'b1;
            buf_addr_q   <= pc_i;
          end else if (!hit) begin
            mem_req_q    <= 1'b1;
            mem_addr_q   <= {pc_i[ADDR_W-1:2], 2'b00};
            buf_addr_q   <= pc_i;
            inst_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            state_q      <= StReq;
          end
        end
        StReq: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
            if (!abandon) begin
              inst_q       <= mem_rdata_i;
              inst_valid_q <= 1'b1;
            end
          end else if (abandon) begin
            // The bus has no withdraw; wait out the ack and throw the data away.
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    unique case (state_q)
      StIdle:  stallreq_o = ce_i & ~flush_i & aligned & ~hit;
      StReq:   stallreq_o = ~mem_ack_i;
      StDrop:  stallreq_o = 1'b1;
      default: stallreq_o = 1'b0;
    endcase
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;
  assign addr_err_o   = addr_err_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp: directed scenarios then randomized PC/ce/flush/latency.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        flush_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        addr_err_o;
  logic        stallreq_o;

  always #5 clk = ~clk;

  inst_fetch_resp #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .ce_i        (ce_i),
    .flush_i     (flush_i),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .inst_o      (inst_o),
    .inst_valid_o(inst_valid_o),
    .addr_err_o  (addr_err_o),
    .stallreq_o  (stallreq_o)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t reg_q[$];
  logic stall_q[$];
  int   checks = 0;
  int   failures = 0;

  // Transaction-level reference: one outstanding fetch (maybe doomed) plus the last delivered word.
  logic        m_busy, m_doomed;
  logic [31:0] m_addr;
  int          m_wait;
  logic        h_valid, h_err;
  logic [31:0] h_inst, h_pc;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_doomed = 0; m_addr = 0; m_wait = 0;
    h_valid = 0; h_err = 0; h_inst = 0; h_pc = 0;
  endtask

  // One cycle: drive inputs at negedge, predict stallreq now and registered outputs after posedge.
  task automatic step(input logic [31:0] pc, input logic c, input logic f, input int w);
    logic ack, hit, exp_stall;
    exp_t e;
    @(negedge clk);
    ack = 1'b0;
    if (m_busy) begin
      if (m_wait == 0) ack = 1'b1;
      else m_wait--;
    end
    pc_i = pc; ce_i = c; flush_i = f; mem_ack_i = ack;
    mem_rdata_i = ack ? mem_word(m_addr) : $urandom;
    if (!m_busy) begin
      hit = h_valid && (pc == h_pc) && !h_err;
      exp_stall = c && !f && (pc[1:0] == 2'b00) && !hit;
      if (f) begin
        h_valid = 0; h_err = 0;
      end else if (!c) begin
        h_valid = 0; h_inst = 0;
      end else if (pc[1:0] != 2'b00) begin
        h_inst = 0; h_valid = 1; h_err = 1; h_pc = pc;
      end else if (!hit) begin
        m_busy = 1; m_doomed = 0; m_addr = pc & 32'hFFFF_FFFC; m_wait = w;
        h_pc = pc; h_valid = 0; h_err = 0;
      end
    end else begin
      exp_stall = m_doomed ? 1'b1 : !ack;
      if (ack) begin
        if (!m_doomed && c && !f) begin
          h_inst = mem_word(m_addr); h_valid = 1;
        end
        m_busy = 0; m_doomed = 0;
      end else if (!m_doomed && (f || !c)) begin
        m_doomed = 1;
      end
    end
    stall_q.push_back(exp_stall);
    e = '{req: m_busy, addr: m_addr, inst: h_inst, valid: h_valid, err: h_err};
    reg_q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    ce_i = 0; flush_i = 0; mem_ack_i = 0;
    rst = 1;
    #1;
    chk("rst_mem_req", {31'b0, mem_req_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_inst_valid", {31'b0, inst_valid_o}, 0);
    chk("rst_addr_err", {31'b0, addr_err_o}, 0);
    chk("rst_stallreq", {31'b0, stallreq_o}, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // Monitor: combinational stall just after inputs settle, registered outputs after each edge.
  initial forever begin
    @(negedge clk);
    #1;
    if (stall_q.size() > 0) chk("stallreq", {31'b0, stallreq_o}, {31'b0, stall_q.pop_front()});
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #2;
    if (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      chk("mem_req", {31'b0, mem_req_o}, {31'b0, e.req});
      chk("mem_addr", mem_addr_o, e.addr);
      chk("inst", inst_o, e.inst);
      chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, e.valid});
      chk("addr_err", {31'b0, addr_err_o}, {31'b0, e.err});
    end
  end

  initial begin
    logic [31:0] cur_pc;
    int r;
    rst = 1; pc_i = 0; ce_i = 0; flush_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    model_reset();
    mem[32'h0] = 32'h3C011234;
    #2;
    chk("init_mem_req", {31'b0, mem_req_o}, 0);
    chk("init_inst", inst_o, 0);
    chk("init_inst_valid", {31'b0, inst_valid_o}, 0);
    @(negedge clk);
    rst = 0;

    // Basic fetch with one wait cycle, then re-presented PC must hit.
    step(32'h0, 1, 0, 1);
    repeat (4) step(32'h0, 1, 0, 0);
    // External stall: PC held after capture, one transaction only.
    repeat (7) step(32'h4, 1, 0, 0);
    // Flush while waiting: dropped transaction, then next PC fetched normally.
    step(32'h8, 1, 0, 3);
    step(32'h8, 1, 1, 0);
    repeat (8) step(32'h380, 1, 0, 1);
    // Misaligned PC.
    repeat (3) step(32'h6, 1, 0, 0);
    // Chip-enable drops mid-request.
    step(32'h10, 1, 0, 2);
    repeat (6) step(32'h10, 0, 0, 0);
    // Asynchronous reset while a request is outstanding.
    step(32'h20, 1, 0, 5);
    step(32'h20, 1, 0, 0);
    pulse_reset();

    cur_pc = 32'h40;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) cur_pc = cur_pc;
      else if (r < 75) cur_pc = (cur_pc & 32'hFFFF_FFFC) + 32'd4;
      else if (r < 90) cur_pc = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      else cur_pc = (cur_pc & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      step(cur_pc, $urandom_range(0, 19) != 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3));
      if ((i % 500) == 499 && m_busy) pulse_reset();
    end

    repeat (2) @(negedge clk);
    chk("queue_drain", reg_q.size() + stall_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
